// File: rtl/out_ctl_if.sv
// out_ctl_if: output stream of the FC-layer output controller.
//   m_valid : word valid (producer -> consumer)
//   m_ready : consumer accepts the word this cycle
//   m_data  : OW-bit signed output word
//   m_last  : word is the final element of a sample
interface out_ctl_if #(
  parameter int OW = 16
) ();
  logic          m_valid;
  logic          m_ready;
  logic [OW-1:0] m_data;
  logic          m_last;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/out_ctl.sv
// out_ctl: output-side controller of the fully-connected layer engine.
// Captures each finished kernel's accumulator, shifts/ReLUs/saturates it to
// OW bits, buffers it in a DEPTH-entry FIFO and streams it out valid/ready.
//   clk      : clock, rising edge
//   rst      : asynchronous reset, active low
//   k_init   : kernel start pulse
//   k_fin    : kernel done pulse, acc_in valid
//   acc_in   : signed accumulator result
//   out_busy : stall next kernel start (FIFO + in-flight kernel would fill it)
//   outrf    : one-cycle pulse after the last element of a sample is taken
//   ovf      : sticky, a result was dropped on a full FIFO
//   m        : output stream (m_valid/m_ready/m_data/m_last)
module out_ctl #(
  parameter int SAMPLE = 40,
  parameter int DEPTH  = 4,
  parameter int DW     = 32,
  parameter int OW     = 16,
  parameter int SHIFT  = 4,
  parameter int RELU   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 k_init,
  input  logic                 k_fin,
  input  logic signed [DW-1:0] acc_in,
  output logic                 out_busy,
  output logic                 outrf,
  output logic                 ovf,
  out_ctl_if.master            m
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int EW = (SAMPLE > 1) ? $clog2(SAMPLE) : 1;

  localparam logic signed [DW-1:0] SAT_HI = {{(DW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [DW-1:0] SAT_LO = {{(DW-OW+1){1'b1}}, {(OW-1){1'b0}}};
  localparam logic [EW-1:0]        EC_LAST = EW'(SAMPLE - 1);

  logic [OW:0]      mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             inflight_q, inflight_d;
  logic [EW-1:0]    ec_q, ec_d;
  logic             outrf_q, outrf_d;
  logic             ovf_q, ovf_d;

  logic signed [DW-1:0] shifted;
  logic [OW-1:0]        q_word;
  logic [OW:0]          head;
  logic                 valid;
  logic                 full;
  logic                 pop;
  logic                 push;
  logic                 elem_last;
  logic [CW:0]          occupancy;

  // Quantizer: floor shift, optional ReLU, signed saturation.
  always_comb begin
    shifted = acc_in >>> SHIFT;
    if ((RELU != 0) && shifted[DW-1]) begin
      q_word = '0;
    end else if (shifted > SAT_HI) begin
      q_word = {1'b0, {(OW-1){1'b1}}};
    end else if (shifted < SAT_LO) begin
      q_word = {1'b1, {(OW-1){1'b0}}};
    end else begin
      q_word = shifted[OW-1:0];
    end
  end

  always_comb begin
    head      = mem_q[rd_ptr_q];
    valid     = (count_q != '0);
    full      = (count_q == CW'(DEPTH));
    pop       = valid & m.m_ready;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    push      = k_fin & (~full | pop);
    elem_last = (ec_q == EC_LAST);
    // Counting the in-flight kernel reserves its slot before it finishes.
    occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ec_d       = ec_q;
    inflight_d = inflight_q;
    ovf_d      = ovf_q | (k_fin & ~push);
    outrf_d    = pop & head[OW];

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      ec_d     = elem_last ? '0 : ec_q + EW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end

    // k_init wins so back-to-back kernels keep the slot reserved.
    if (k_init) begin
      inflight_d = 1'b1;
    end else if (k_fin) begin
      inflight_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      ec_q       <= '0;
      outrf_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      ec_q       <= ec_d;
      outrf_q    <= outrf_d;
      ovf_q      <= ovf_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {elem_last, q_word};
    end
  end

  assign m.m_valid = valid;
  assign m.m_data  = valid ? head[OW-1:0] : '0;
  assign m.m_last  = valid & head[OW];
  assign out_busy  = (occupancy >= (CW+1)'(DEPTH));
  assign outrf     = outrf_q;
  assign ovf       = ovf_q;

endmodule

// File: doc/out_ctl.md
# out_ctl

Output-side controller for the fully-connected layer engine. It sits downstream of the execution controller. It captures each finished kernel's accumulator result, scales and saturates it, and buffers it in a small FIFO. It streams the results out under a valid/ready handshake, and returns `out_busy` (stall the next kernel start) and `outrf` (sample fully drained) to the execution controller.

## Interface
- `SAMPLE`, 40: results per sample (kernels per `s_init` run); element counter wraps at this count.
- `DEPTH`, 4: result FIFO depth (power of two, ≥2).
- `DW`, 32: accumulator width, signed.
- `OW`, 16: output word width, signed.
- `SHIFT`, 4: arithmetic right shift applied to the accumulator (0..DW-OW).
- `RELU`, 1: 1 = clamp negative results to 0.

Ports:
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low (0 = reset).
- `k_init`  in  1  kernel start pulse from execution controller.
- `k_fin`  in  1  kernel done pulse; `acc_in` valid this cycle.
- `acc_in`  in  DW  signed accumulator result.
- `out_busy`  out  1  stall request to execution controller.
- `outrf`  out  1  one-cycle pulse: last element of a sample accepted downstream.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  downstream accepts word.
- `m_data`  out  OW  output word.
- `m_last`  out  1  marks element SAMPLE-1 of the sample.
- `ovf`  out  1  sticky: a result was dropped on a full FIFO.

## Operation
- State: FIFO (`DEPTH` entries, `OW`+1 bits each: data + last flag), `count` (0..DEPTH), `inflight` flag, element counter `ec` (0..SAMPLE-1), `outrf` reg, `ovf` reg.
- Quantize (combinational on `acc_in`): `s = acc_in >>> SHIFT` (floor). If `RELU` and `s<0` → 0. Else saturate to signed OW: `s > 2^(OW-1)-1` → `0x7FFF` (OW=16); `s < -2^(OW-1)` → `0x8000`.
- Push: `k_fin`=1 and (`count<DEPTH` or pop this cycle) → write quantized word with `last = (ec==SAMPLE-1)`. `ec` increments, wrapping SAMPLE-1→0.
- Push on full without simultaneous pop → word dropped, `ec` unchanged, `ovf`←1 until reset.
- Pop: `m_valid & m_ready`. `m_valid = (count!=0)`. `m_data`/`m_last` come from the FIFO head, forced to 0 when `count==0`.
- Push and pop in the same cycle: `count` unchanged, both pointers advance.
- `inflight`: set by `k_init`, cleared by `k_fin`. Both in the same cycle → stays 1 (back-to-back kernels).
- `out_busy = (count + inflight) >= DEPTH`. Combinational from registers only; no path from `k_init` or `m_ready`. This guarantees the kernel admitted by the last `k_init` always has a free slot at its `k_fin`.
- `outrf`: registered. Set for exactly one cycle after a pop with `m_last`=1.

## Timing
- Reset values: `out_busy`=0, `outrf`=0, `m_valid`=0, `m_data`=0, `m_last`=0, `ovf`=0. Reset also zeroes `count`, `inflight`, `ec` and the pointers, asynchronously, mid-transfer included; pending words are discarded.
- `k_fin` in cycle t into an empty FIFO → `m_valid`=1 in cycle t+1 with that word.
- Pop of the `m_last` word in cycle t → `outrf`=1 in cycle t+1 only.
- `out_busy` reflects a cycle-t push/pop/`k_init` in cycle t+1.
- `m_valid` never drops without a pop. `m_data` is stable while `m_valid & !m_ready`.
- Full throughput: one word per cycle when `m_ready`=1.

## Test plan
- Reset released, no stimulus → all outputs 0 for 10 cycles; `out_busy`=0.
- `k_init`, then `k_fin` with `acc_in`=0x00001234 (`m_ready`=1, defaults) → next cycle `m_valid`=1, `m_data`=0x0123, `m_last`=0; popped that cycle.
- `acc_in`=0x7FFFFFFF → `m_data`=0x7FFF. `acc_in`=0xFFFFFFFB with RELU=1 → 0x0000. Same with RELU=0 → 0xFFFF.
- `m_ready`=0: three results pushed, then `k_init` → `out_busy`=1 the next cycle. One pop → `out_busy`=0 one cycle later. The fourth `k_fin` is stored and `ovf` stays 0.
- 40 kernels with `m_ready`=1 → `m_last` only on word 40, `outrf` a single pulse one cycle after it. A following sample's first word has `m_last`=0 (`ec` wrapped).
- `count`=4, `m_ready`=0, extra `k_fin` → `ovf`=1 (stays 1), FIFO contents and `ec` unchanged. Assert `rst` low → `ovf`=0, `m_valid`=0 immediately.
